// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch front-end.
// Imported by the fetch queue and its FIFO.
package mips_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = ~32'h3;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs with flush.
// Head entry is read straight from the storage flops.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fq_entry_t     din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fq_entry_t     head_o,
  output logic [CW-1:0] count_o
);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          pop_ok;

  assign pop_ok = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_ok);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction fetch front-end: in-order requests to a variable-latency
// memory, credit-limited buffering, and redirect with response dropping.
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = RESET_PC_DEF,
  localparam int          CW       = $clog2(DEPTH + 1)
) (
  input  logic        CLK,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4
);

  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  fq_entry_t     head;
  fq_entry_t     din;

  // Credits cover both buffered words and words still in flight.
  assign used     = {1'b0, count} + {1'b0, out_q};
  assign imem_req = !rst && !redirect && (used < CAP);
  assign accept   = imem_req && imem_gnt;
  assign dropping = (drop_q != '0);
  assign push     = imem_rvalid && !dropping && !redirect;
  assign pop      = out_valid && out_ready;
  assign din      = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_rvalid);
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      resp_pc_d  = redirect_pc & ALIGN_MASK;
      drop_d     = out_q - CW'(imem_rvalid);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + PC_INC;
      end
      if (imem_rvalid && dropping) begin
        drop_d = drop_q - CW'(1);
      end else if (imem_rvalid) begin
        resp_pc_d = resp_pc_q + PC_INC;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (rst),
    .push_i (push),
    .din_i  (din),
    .pop_i  (pop),
    .flush_i(redirect),
    .head_o (head),
    .count_o(count)
  );

  assign imem_addr    = fetch_pc_q;
  assign out_valid    = (count != '0);
  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_pc_plus4 = head.pc + PC_INC;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue with an in-order memory model.
// Instruction word returned for address A is ~A.
module tb_mips_fetch_queue;

  logic        CLK;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;

  mips_fetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_pc_plus4(out_pc_plus4)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] a;
    int          rdy;
  } req_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  req_t pend[$];
  vec_t tv[14];
  int   nchk = 0;
  int   nerr = 0;
  int   ncyc = 0;
  int   lat = 1;
  bit   rand_lat = 0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;

  task automatic check(string nm, bit ok, logic [31:0] act, logic [31:0] req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    check(nm, act == req, act, req);
  endtask

  // One clock: sample handshakes, advance, then update the memory model.
  task automatic tick();
    bit          acc;
    bit          pp;
    logic [31:0] a;
    int          l;
    acc = imem_req && imem_gnt;
    a   = imem_addr;
    pp  = out_valid && out_ready;
    @(posedge CLK);
    #1;
    ncyc++;
    if (acc) begin
      acc_cnt++;
      l = rand_lat ? int'($urandom_range(1, 4)) : lat;
      pend.push_back('{a, ncyc + l - 1});
    end
    if (pp) pop_cnt++;
    imem_rvalid = 0;
    imem_rdata  = '0;
    if (pend.size() != 0 && pend[0].rdy <= ncyc) begin
      imem_rvalid = 1;
      imem_rdata  = ~pend[0].a;
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    rst         = 1;
    imem_rvalid = 0;
    imem_rdata  = '0;
    redirect    = 0;
    pend.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 0;
  endtask

  task automatic expect_pc(string nm, logic [31:0] pc);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      #1;
      n++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_pc"}, out_pc, pc);
    chk({nm, "_instr"}, out_instr, ~pc);
    chk({nm, "_plus4"}, out_pc_plus4, pc + 32'd4);
    tick();
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;

    rst         = 1;
    imem_gnt    = 0;
    imem_rvalid = 0;
    imem_rdata  = '0;
    redirect    = 0;
    redirect_pc = '0;
    out_ready   = 0;

    // rst gnt rdy | req addr vld pc
    tv[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
    tv[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
    tv[2]  = '{0, 1, 1, 1, 32'h08, 1, 32'h00};
    tv[3]  = '{0, 1, 1, 1, 32'h0C, 1, 32'h04};
    tv[4]  = '{0, 1, 1, 1, 32'h10, 1, 32'h08};
    tv[5]  = '{0, 1, 1, 1, 32'h14, 1, 32'h0C};
    tv[6]  = '{1, 1, 0, 1, 32'h00, 0, 32'h00};
    tv[7]  = '{0, 1, 0, 1, 32'h04, 0, 32'h00};
    tv[8]  = '{0, 1, 0, 1, 32'h08, 1, 32'h00};
    tv[9]  = '{0, 1, 0, 1, 32'h0C, 1, 32'h00};
    tv[10] = '{0, 1, 0, 0, 32'h10, 1, 32'h00};
    tv[11] = '{0, 1, 0, 0, 32'h10, 1, 32'h00};
    tv[12] = '{0, 1, 1, 0, 32'h10, 1, 32'h00};
    tv[13] = '{0, 1, 1, 1, 32'h10, 1, 32'h04};

    lat      = 1;
    rand_lat = 0;
    for (int i = 0; i < 14; i++) begin
      if (tv[i].rst) do_reset();
      imem_gnt  = tv[i].gnt;
      out_ready = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d_req", i), imem_req, tv[i].req);
      chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), out_valid, tv[i].vld);
      chk($sformatf("tv%0d_pc", i), out_pc, tv[i].pc);
      chk($sformatf("tv%0d_plus4", i), out_pc_plus4, tv[i].pc + 32'd4);
      if (tv[i].vld) chk($sformatf("tv%0d_instr", i), out_instr, ~tv[i].pc);
      tick();
    end

    // Two requests in flight at 3-cycle latency, then redirect.
    do_reset();
    lat       = 3;
    imem_gnt  = 1;
    out_ready = 1;
    #1;
    tick();
    tick();
    imem_gnt    = 0;
    redirect    = 1;
    redirect_pc = 32'h103;
    #1;
    chk("t3_req_in_redirect", imem_req, 0);
    tick();
    redirect = 0;
    imem_gnt = 1;
    #1;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_flushed", out_valid, 0);
    expect_pc("t3_first", 32'h100);
    expect_pc("t3_second", 32'h104);

    // Redirect in the same cycle as a returning response.
    do_reset();
    lat       = 2;
    imem_gnt  = 1;
    out_ready = 1;
    #1;
    repeat (4) tick();
    chk("t4_rvalid_setup", imem_rvalid, 1);
    redirect    = 1;
    redirect_pc = 32'h200;
    #1;
    chk("t4_req_in_redirect", imem_req, 0);
    tick();
    redirect = 0;
    #1;
    chk("t4_flushed", out_valid, 0);
    expect_pc("t4_a", 32'h200);
    expect_pc("t4_b", 32'h204);
    expect_pc("t4_c", 32'h208);

    // Address wrap at the top of the address space.
    redirect    = 1;
    redirect_pc = 32'hFFFF_FFFA;
    #1;
    tick();
    redirect = 0;
    #1;
    expect_pc("t7_a", 32'hFFFF_FFF8);
    expect_pc("t7_b", 32'hFFFF_FFFC);
    expect_pc("t7_c", 32'h0000_0000);

    // Toggling grant, random latency, random backpressure.
    do_reset();
    rand_lat = 1;
    exp_pc   = 32'h0;
    for (int c = 0; c < 80; c++) begin
      imem_gnt  = (c % 2 == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("t5_pc%0d", c), out_pc, exp_pc);
        chk($sformatf("t5_instr%0d", c), out_instr, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      tick();
      check($sformatf("t5_credit%0d", c), (acc_cnt - pop_cnt) <= 4,
            32'(acc_cnt - pop_cnt), 32'd4);
    end
    check("t5_progress", pop_cnt >= 10, 32'(pop_cnt), 32'd10);

    // Asynchronous reset off the clock edge in mid-stream.
    imem_gnt  = 1;
    out_ready = 1;
    rand_lat  = 0;
    lat       = 1;
    #2;
    rst = 1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_req", imem_req, 0);
    chk("t6_pc", out_pc, 32'h0);
    chk("t6_instr", out_instr, 32'h0);
    chk("t6_plus4", out_pc_plus4, 32'h4);
    imem_rvalid = 0;
    imem_rdata  = '0;
    pend.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 0;
    #1;
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    expect_pc("t6_a", 32'h0);
    expect_pc("t6_b", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
